// File: rtl/dpram_wr_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dpram_wr_ctrl
//
// Writes a byte stream into the A port of a dual-port RAM split into two
// ping-pong banks. A frame ends on s_last or when the bank is full. The bank
// is then handed to the port-B reader through bank_rdy / bank_lenN, and writing
// moves to the other bank. The reader hands a bank back with a bank_rel pulse.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready      byte stream in (valid/ready handshake)
//   addra/dina/ena/wea  dpram port-A write, registered one cycle after accept
//   bank_rdy[1:0]       bank b holds a complete block for the reader
//   bank_len0/1         byte count of bank 0/1, valid while bank_rdy[b] is high
//   bank_rel[1:0]       one-cycle release pulse per bank from the reader
// -----------------------------------------------------------------------------
module dpram_wr_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              ena,
    output logic              wea,
    output logic [1:0]        bank_rdy,
    output logic [ADDR_W-1:0] bank_len0,
    output logic [ADDR_W-1:0] bank_len1,
    input  logic [1:0]        bank_rel
);

    localparam int OFF_W = ADDR_W - 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                s_ready_q, s_ready_d;
    logic                wbank_q, wbank_d;
    logic [OFF_W-1:0]    wptr_q, wptr_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   dina_q, dina_d;
    logic                wen_q, wen_d;
    logic [1:0]          bank_rdy_q, bank_rdy_d;
    logic [ADDR_W-1:0]   len0_q, len0_d;
    logic [ADDR_W-1:0]   len1_q, len1_d;
    // A closed bank is announced two edges after its last accept: pend1 marks
    // the edge the final RAM write happens, pend2 the edge bank_rdy rises.
    logic [1:0]          pend1_q, pend1_d;
    logic [1:0]          pend2_q, pend2_d;

    logic                accept;
    logic                close_frame;
    logic                new_bank;
    logic [1:0]          busy;

    assign accept      = s_valid && s_ready_q;
    assign close_frame = accept && (s_last || (wptr_q == {OFF_W{1'b1}}));
    assign new_bank    = ~wbank_q;
    // A bank is unavailable for writing while the reader owns it or while its
    // hand-over is still in flight.
    assign busy        = bank_rdy_q | pend1_q | pend2_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        wbank_d    = wbank_q;
        wptr_d     = wptr_q;
        addra_d    = addra_q;
        dina_d     = dina_q;
        wen_d      = 1'b0;
        len0_d     = len0_q;
        len1_d     = len1_q;
        pend1_d    = 2'b00;
        pend2_d    = pend1_q;
        // Releases only affect banks that are actually ready; a pending bank
        // has bank_rdy_q low, so a release aimed at it falls away here.
        bank_rdy_d = (bank_rdy_q & ~bank_rel) | pend2_q;

        if (accept) begin
            addra_d = {wbank_q, wptr_q};
            dina_d  = s_data;
            wen_d   = 1'b1;
            if (close_frame) begin
                if (wbank_q) len1_d = {1'b0, wptr_q} + ADDR_W'(1);
                else         len0_d = {1'b0, wptr_q} + ADDR_W'(1);
                wptr_d           = '0;
                wbank_d          = new_bank;
                pend1_d[wbank_q] = 1'b1;
            end else begin
                wptr_d = wptr_q + OFF_W'(1);
            end
        end

        unique case (state_q)
            ST_FILL: begin
                if (close_frame && busy[new_bank]) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!busy[wbank_q]) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase

        // s_ready is a registered copy of the state so it tracks FILL exactly,
        // yet stays low during reset and rises on the first edge after it.
        s_ready_d = (state_d == ST_FILL);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            s_ready_q  <= 1'b0;
            wbank_q    <= 1'b0;
            wptr_q     <= '0;
            addra_q    <= '0;
            dina_q     <= '0;
            wen_q      <= 1'b0;
            bank_rdy_q <= 2'b00;
            len0_q     <= '0;
            len1_q     <= '0;
            pend1_q    <= 2'b00;
            pend2_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            wbank_q    <= wbank_d;
            wptr_q     <= wptr_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            wen_q      <= wen_d;
            bank_rdy_q <= bank_rdy_d;
            len0_q     <= len0_d;
            len1_q     <= len1_d;
            pend1_q    <= pend1_d;
            pend2_q    <= pend2_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign ena       = wen_q;
    assign wea       = wen_q;
    assign bank_rdy  = bank_rdy_q;
    assign bank_len0 = len0_q;
    assign bank_len1 = len1_q;

endmodule

// File: tb/tb_dpram_wr_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dpram_wr_ctrl
//
// Self-checking bench for dpram_wr_ctrl: a vector table for the basic frame,
// hand-written sequences for bank-full, wait/release and mid-frame reset, and
// a randomized run. Every edge is also compared against a transaction-level
// reference model (bank/offset arithmetic, hand-over timestamps).
// -----------------------------------------------------------------------------
module tb_dpram_wr_ctrl;

    localparam int BANK_BYTES = 32768;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [15:0] addra;
    logic [7:0]  dina;
    logic        ena;
    logic        wea;
    logic [1:0]  bank_rdy;
    logic [15:0] bank_len0;
    logic [15:0] bank_len1;
    logic [1:0]  bank_rel;

    dpram_wr_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .addra    (addra),
        .dina     (dina),
        .ena      (ena),
        .wea      (wea),
        .bank_rdy (bank_rdy),
        .bank_len0(bank_len0),
        .bank_len1(bank_len1),
        .bank_rel (bank_rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_bank;      // bank currently being written
    int         m_cnt;       // bytes already written into the current frame
    int         m_len[2];
    logic [1:0] m_rdy;
    int         m_pend[2];   // edge number at which bank_rdy rises, -1 if none
    bit         m_blocked;
    bit         m_sready;
    bit         m_ena;
    int         m_addr;
    logic [7:0] m_din;
    int         edge_n;

    task automatic model_reset();
        m_bank = 0; m_cnt = 0;
        m_len[0] = 0; m_len[1] = 0;
        m_rdy = 2'b00;
        m_pend[0] = -1; m_pend[1] = -1;
        m_blocked = 0; m_sready = 0;
        m_ena = 0; m_addr = 0; m_din = 8'h00;
        edge_n = 0;
    endtask

    task automatic model_step(input logic v, input logic l, input logic [7:0] d, input logic [1:0] rel);
        bit busy[2];
        bit acc;
        edge_n++;
        for (int b = 0; b < 2; b++) busy[b] = m_rdy[b] || (m_pend[b] != -1);
        acc = v && m_sready;
        for (int b = 0; b < 2; b++) begin
            m_rdy[b] = (m_rdy[b] && !rel[b]) || (m_pend[b] == edge_n);
            if (m_pend[b] == edge_n) m_pend[b] = -1;
        end
        m_ena = acc;
        if (acc) begin
            m_addr = m_bank * BANK_BYTES + m_cnt;
            m_din  = d;
            if (l || m_cnt == BANK_BYTES - 1) begin
                m_len[m_bank]  = m_cnt + 1;
                m_pend[m_bank] = edge_n + 2;
                m_bank         = 1 - m_bank;
                m_cnt          = 0;
                m_blocked      = busy[m_bank];
            end else begin
                m_cnt++;
            end
        end else if (m_blocked && !busy[m_bank]) begin
            m_blocked = 0;
        end
        m_sready = !m_blocked;
    endtask

    task automatic compare_model();
        check("m_s_ready", 32'(s_ready), 32'(m_sready));
        check("m_ena", 32'(ena), 32'(m_ena));
        check("m_wea", 32'(wea), 32'(m_ena));
        if (m_ena) begin
            check("m_addra", 32'(addra), 32'(m_addr));
            check("m_dina", 32'(dina), 32'(m_din));
        end
        check("m_bank_rdy", 32'(bank_rdy), 32'(m_rdy));
        check("m_bank_len0", 32'(bank_len0), 32'(m_len[0]));
        check("m_bank_len1", 32'(bank_len1), 32'(m_len[1]));
    endtask

    // Drive one cycle of inputs, take the edge, sample 1 ns later.
    task automatic step(input logic v, input logic l, input logic [7:0] d, input logic [1:0] rel);
        s_valid = v; s_last = l; s_data = d; bank_rel = rel;
        @(posedge clk);
        #1;
        model_step(v, l, d, rel);
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 2'b00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_addra"}, 32'(addra), 32'd0);
        check({tag, "_dina"}, 32'(dina), 32'd0);
        check({tag, "_ena"}, 32'(ena), 32'd0);
        check({tag, "_wea"}, 32'(wea), 32'd0);
        check({tag, "_bank_rdy"}, 32'(bank_rdy), 32'd0);
        check({tag, "_bank_len0"}, 32'(bank_len0), 32'd0);
        check({tag, "_bank_len1"}, 32'(bank_len1), 32'd0);
    endtask

    // Asserts reset where the caller stands (possibly mid-frame), checks the
    // outputs clear at once and stay clear across an edge, then releases.
    task automatic do_reset(input string tag);
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; bank_rel = 2'b00;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs({tag, "_async"});
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        v;
        logic        l;
        logic [7:0]  d;
        logic [1:0]  rel;
        logic        e_sready;
        logic        e_ena;
        logic [15:0] e_addr;
        logic [7:0]  e_din;
        logic [1:0]  e_brdy;
        logic [15:0] e_len0;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    initial begin
        rst_n = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; bank_rel = 2'b00;
        model_reset();

        // Basic frame: bytes 1..8, close, hand-over two edges later, release,
        // then the next byte lands in bank 1.
        vecs[0] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 16'h0000, 8'h00, 2'b00, 16'd0};
        for (int i = 1; i <= 8; i++)
            vecs[i] = '{1'b1, (i == 8), 8'(i), 2'b00, 1'b1, 1'b1, 16'(i - 1), 8'(i), 2'b00,
                        (i == 8) ? 16'd8 : 16'd0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 16'h0000, 8'h00, 2'b00, 16'd8};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 16'h0000, 8'h00, 2'b01, 16'd8};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 16'h0000, 8'h00, 2'b00, 16'd8};
        vecs[12] = '{1'b1, 1'b0, 8'h55, 2'b00, 1'b1, 1'b1, 16'h8000, 8'h55, 2'b00, 16'd8};

        #2;
        do_reset("rst0");
        for (int k = 0; k < NVEC; k++) begin
            step(vecs[k].v, vecs[k].l, vecs[k].d, vecs[k].rel);
            check("tbl_s_ready", 32'(s_ready), 32'(vecs[k].e_sready));
            check("tbl_ena", 32'(ena), 32'(vecs[k].e_ena));
            check("tbl_wea", 32'(wea), 32'(vecs[k].e_ena));
            if (vecs[k].e_ena) begin
                check("tbl_addra", 32'(addra), 32'(vecs[k].e_addr));
                check("tbl_dina", 32'(dina), 32'(vecs[k].e_din));
            end
            check("tbl_bank_rdy", 32'(bank_rdy), 32'(vecs[k].e_brdy));
            check("tbl_bank_len0", 32'(bank_len0), 32'(vecs[k].e_len0));
        end

        // Both banks filled with 3-byte frames and no release: writer stalls.
        do_reset("rst1");
        idle(1);
        for (int f = 0; f < 2; f++)
            for (int j = 0; j < 3; j++) step(1'b1, (j == 2), 8'(16 * f + j), 2'b00);
        check("full_s_ready_low", 32'(s_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'hEE, 2'b00);
            check("full_no_ena", 32'(ena), 32'd0);
            check("full_no_wea", 32'(wea), 32'd0);
            check("full_s_ready", 32'(s_ready), 32'd0);
        end
        check("full_rdy_both", 32'(bank_rdy), 32'd3);
        check("full_len0", 32'(bank_len0), 32'd3);
        check("full_len1", 32'(bank_len1), 32'd3);
        step(1'b0, 1'b0, 8'h00, 2'b01);
        check("rel0_rdy", 32'(bank_rdy), 32'd2);
        check("rel0_s_ready_still_low", 32'(s_ready), 32'd0);
        idle(1);
        check("rel0_s_ready_up", 32'(s_ready), 32'd1);
        step(1'b1, 1'b0, 8'h77, 2'b00);
        check("rel0_addr_bank0", 32'(addra), 32'h0000);
        check("rel0_ena", 32'(ena), 32'd1);

        // Releases of a bank that is not ready are ignored; both at once work.
        do_reset("rst2");
        idle(1);
        step(1'b1, 1'b0, 8'h01, 2'b00);
        step(1'b1, 1'b1, 8'h02, 2'b00);
        idle(2);
        check("rel_setup_rdy01", 32'(bank_rdy), 32'd1);
        step(1'b0, 1'b0, 8'h00, 2'b10);
        check("rel_wrong_bank_ignored", 32'(bank_rdy), 32'd1);
        step(1'b1, 1'b1, 8'h03, 2'b00);
        check("one_byte_addr", 32'(addra), 32'h8000);
        idle(2);
        check("rel_setup_rdy11", 32'(bank_rdy), 32'd3);
        check("one_byte_len1", 32'(bank_len1), 32'd1);
        step(1'b0, 1'b0, 8'h00, 2'b11);
        check("rel_both", 32'(bank_rdy), 32'd0);
        check("len0_held_after_rel", 32'(bank_len0), 32'd2);
        check("len1_held_after_rel", 32'(bank_len1), 32'd1);

        // Reset in the middle of a frame, with bank 0 handed over.
        do_reset("rst3");
        idle(1);
        step(1'b1, 1'b0, 8'h10, 2'b00);
        step(1'b1, 1'b1, 8'h11, 2'b00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 2'b00);
        check("mid_pre_rdy", 32'(bank_rdy), 32'd1);
        check("mid_pre_addr", 32'(addra), 32'h8004);
        do_reset("mid");
        idle(1);
        check("mid_post_s_ready", 32'(s_ready), 32'd1);
        step(1'b1, 1'b0, 8'hAA, 2'b00);
        check("mid_post_addr", 32'(addra), 32'h0000);
        check("mid_post_ena", 32'(ena), 32'd1);
        check("mid_post_rdy", 32'(bank_rdy), 32'd0);

        // A full bank with no s_last closes on its own.
        do_reset("rst4");
        idle(1);
        for (int i = 0; i < BANK_BYTES; i++) step(1'b1, 1'b0, i[7:0], 2'b00);
        check("full_bank_last_addr", 32'(addra), 32'h7FFF);
        step(1'b1, 1'b0, 8'h5A, 2'b00);
        check("full_bank_next_addr", 32'(addra), 32'h8000);
        check("full_bank_len0", 32'(bank_len0), 32'd32768);
        idle(1);
        check("full_bank_rdy", 32'(bank_rdy), 32'd1);

        // Randomized traffic with short frames and sparse releases.
        do_reset("rst5");
        for (int i = 0; i < 4000; i++) begin
            logic       rv;
            logic       rl;
            logic [1:0] rr;
            rv = ($urandom % 4) != 0;
            rl = ($urandom % 4) == 0;
            rr[0] = ($urandom % 8) == 0;
            rr[1] = ($urandom % 8) == 0;
            step(rv, rl, 8'($urandom), rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
